wm_panel_ctrl: RTL

//  Front-panel input stage of the washing machine, sitting directly upstream of the FSMW controller.

---
 rtl/wm_pkg.sv | 22 ++
 rtl/wm_debounce.sv | 45 ++++
 rtl/wm_panel_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/wm_pkg.sv
// rtl/wm_pkg.sv - shared program codes, panel state encoding and widths for the washing-machine front panel
// Contents: PROG_W, program code constants, panel state constants, prog_valid() helper.
package wm_pkg;

    localparam int PROG_W = 3;

    localparam logic [PROG_W-1:0] COLD_WASH   = 3'b000;
    localparam logic [PROG_W-1:0] HOT_WASH    = 3'b001;
    localparam logic [PROG_W-1:0] RINSING_DRY = 3'b010;
    localparam logic [PROG_W-1:0] ONLY_DRY    = 3'b011;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    // Only the four codes 0xx are real programs; anything with the MSB set is rejected.
    function automatic logic prog_valid(input logic [PROG_W-1:0] code);
        return (code == COLD_WASH) || (code == HOT_WASH) ||
               (code == RINSING_DRY) || (code == ONLY_DRY);
    endfunction

endpackage

// File: rtl/wm_debounce.sv
// rtl/wm_debounce.sv - 2-FF synchroniser plus stability counter for one W-bit panel input
// Ports:
//   clk  in   system clock, rising edge
//   clr  in   synchronous clear of synchroniser, counter and output (reset or power off)
//   raw  in   W  asynchronous raw input
//   db   out  W  debounced value
module wm_debounce #(
    parameter int W         = 1,
    parameter int DB_CYCLES = 4,
    parameter int DB_W      = 3
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [W-1:0] raw,
    output logic [W-1:0] db
);

    logic [W-1:0]    s1;
    logic [W-1:0]    s2;
    logic [DB_W-1:0] cnt;

    // A single counter covers the whole vector: any bit differing from db keeps
    // counting, and returning to db at any point clears it, so a partial change
    // of a multi-bit selector restarts the stability window.
    always_ff @(posedge clk) begin
        if (clr) begin
            s1  <= '0;
            s2  <= '0;
            cnt <= '0;
            db  <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == DB_W'(DB_CYCLES - 1)) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wm_panel_ctrl.sv
// rtl/wm_panel_ctrl.sv - washing-machine front panel: debounced inputs, start edge detect and IDLE/RUN/DONE door-lock FSM
// Ports:
//   clk, rst (sync, active-high), power (0 = synchronous clear)
//   btn_start_raw, door_sw_raw, soap_sw_raw, prog_sel_raw[2:0]  raw panel inputs
//   program_done        completion flag from FSMW
//   program_selection   latched program to FSMW
//   start               one-cycle start pulse
//   doorclosed, soap    debounced door/soap state
//   door_lock, busy     door solenoid and running flag
//   sel_error, door_warn  one-cycle rejection pulses
module wm_panel_ctrl
    import wm_pkg::*;
#(
    parameter int DB_CYCLES = 4,
    parameter int DB_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              power,
    input  logic              btn_start_raw,
    input  logic              door_sw_raw,
    input  logic              soap_sw_raw,
    input  logic [PROG_W-1:0] prog_sel_raw,
    input  logic              program_done,
    output logic [PROG_W-1:0] program_selection,
    output logic              start,
    output logic              doorclosed,
    output logic              soap,
    output logic              door_lock,
    output logic              busy,
    output logic              sel_error,
    output logic              door_warn
);

    logic              clr;
    logic              db_start;
    logic              db_start_q;
    logic              db_door;
    logic              db_soap;
    logic [PROG_W-1:0] db_prog;
    logic              press;
    logic [1:0]        state;

    // Power-off behaves exactly like reset, including the debounce pipelines.
    assign clr = rst | ~power;

    wm_debounce #(.W(1), .DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_start (
        .clk(clk), .clr(clr), .raw(btn_start_raw), .db(db_start)
    );
    wm_debounce #(.W(1), .DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_door (
        .clk(clk), .clr(clr), .raw(door_sw_raw), .db(db_door)
    );
    wm_debounce #(.W(1), .DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_soap (
        .clk(clk), .clr(clr), .raw(soap_sw_raw), .db(db_soap)
    );
    wm_debounce #(.W(PROG_W), .DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_prog (
        .clk(clk), .clr(clr), .raw(prog_sel_raw), .db(db_prog)
    );

    assign doorclosed = db_door;
    assign soap       = db_soap;
    assign press      = db_start & ~db_start_q;

    always_ff @(posedge clk) begin
        if (rst || !power) begin
            db_start_q        <= 1'b0;
            state             <= IDLE;
            program_selection <= '0;
            start             <= 1'b0;
            door_lock         <= 1'b0;
            busy              <= 1'b0;
            sel_error         <= 1'b0;
            door_warn         <= 1'b0;
        end else begin
            db_start_q <= db_start;
            start      <= 1'b0;
            sel_error  <= 1'b0;
            door_warn  <= 1'b0;
            case (state)
                RUN: begin
                    // A press arriving with program_done is simply dropped.
                    if (program_done) begin
                        door_lock <= 1'b0;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                IDLE, DONE: begin
                    if (press) begin
                        if (!db_door) begin
                            door_warn <= 1'b1;
                            state     <= IDLE;
                        end else if (!prog_valid(db_prog)) begin
                            sel_error <= 1'b1;
                        end else begin
                            program_selection <= db_prog;
                            start             <= 1'b1;
                            door_lock         <= 1'b1;
                            busy              <= 1'b1;
                            state             <= RUN;
                        end
                    end else if (state == DONE && !db_door) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
